// File: rtl/ctrl_pkg.sv
// Shared constants for the pipelined control unit: opcodes, ALU/jump codes,
// bundle field widths, sequencer state encoding and the write-back helper.
package ctrl_pkg;

  localparam int OPCODE_W_D = 5;
  localparam int ALU_OP_W_D = 4;
  localparam int JUMP_W_D   = 3;

  localparam logic [4:0] OP_SETC = 5'd1;
  localparam logic [4:0] OP_CLRC = 5'd2;
  localparam logic [4:0] OP_NOT  = 5'd3;
  localparam logic [4:0] OP_INC  = 5'd4;
  localparam logic [4:0] OP_DEC  = 5'd5;
  localparam logic [4:0] OP_IN   = 5'd6;
  localparam logic [4:0] OP_OUT  = 5'd7;
  localparam logic [4:0] OP_PUSH = 5'd8;
  localparam logic [4:0] OP_POP  = 5'd9;
  localparam logic [4:0] OP_LDD  = 5'd10;
  localparam logic [4:0] OP_STD  = 5'd12;
  localparam logic [4:0] OP_LDM  = 5'd13;
  localparam logic [4:0] OP_JZ   = 5'd16;
  localparam logic [4:0] OP_JN   = 5'd17;
  localparam logic [4:0] OP_JC   = 5'd18;
  localparam logic [4:0] OP_JMP  = 5'd19;
  localparam logic [4:0] OP_CALL = 5'd20;
  localparam logic [4:0] OP_RET  = 5'd21;
  localparam logic [4:0] OP_RETI = 5'd22;
  localparam logic [4:0] OP_MOV  = 5'd24;
  localparam logic [4:0] OP_ADD  = 5'd25;
  localparam logic [4:0] OP_SUB  = 5'd26;
  localparam logic [4:0] OP_AND  = 5'd28;
  localparam logic [4:0] OP_OR   = 5'd29;
  localparam logic [4:0] OP_SHL  = 5'd30;
  localparam logic [4:0] OP_SHR  = 5'd31;

  localparam logic [3:0] ALU_NOT  = 4'd1;
  localparam logic [3:0] ALU_INC  = 4'd2;
  localparam logic [3:0] ALU_DEC  = 4'd3;
  localparam logic [3:0] ALU_MOV  = 4'd4;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_SHL  = 4'd9;
  localparam logic [3:0] ALU_SHR  = 4'd10;
  localparam logic [3:0] ALU_SETC = 4'd11;
  localparam logic [3:0] ALU_CLRC = 4'd12;

  localparam logic [2:0] J_NONE = 3'd0;
  localparam logic [2:0] J_JMP  = 3'd1;
  localparam logic [2:0] J_JZ   = 3'd2;
  localparam logic [2:0] J_JN   = 3'd3;
  localparam logic [2:0] J_JC   = 3'd4;
  localparam logic [2:0] J_CALL = 3'd5;
  localparam logic [2:0] J_RET  = 3'd6;
  localparam logic [2:0] J_RETI = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CALL_PUSH  = 3'd1,
    ST_RET_POP    = 3'd2,
    ST_RETI_FLAGS = 3'd3,
    ST_RETI_POP   = 3'd4
  } seq_state_e;

  function automatic logic calc_wb(input logic alu_nz, input logic mem_read,
                                   input logic pop, input logic in_port);
    return alu_nz | mem_read | pop | in_port;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode -> ID control bundle decoder; CALL/RET/RETI only
// raise request flags, their bundles come from the sequencer.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_D,
  parameter int ALU_OP_W = ALU_OP_W_D,
  parameter int JUMP_W   = JUMP_W_D
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                valid,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                wb,
  output logic                push,
  output logic                pop,
  output logic                in_port,
  output logic                out_port,
  output logic                imm,
  output logic [JUMP_W-1:0]   jump_type,
  output logic                one_operand,
  output logic                seq_call,
  output logic                seq_ret,
  output logic                seq_reti
);

  // opcode table lookup, bubbles decode to all-zero
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    alu_op      = {ALU_OP_W{1'b0}};
    push        = 1'b0;
    pop         = 1'b0;
    in_port     = 1'b0;
    out_port    = 1'b0;
    imm         = 1'b0;
    jump_type   = {JUMP_W{1'b0}};
    one_operand = 1'b0;
    seq_call    = 1'b0;
    seq_ret     = 1'b0;
    seq_reti    = 1'b0;
    if (valid) begin
      case (opcode)
        OPCODE_W'(OP_SETC): alu_op = ALU_OP_W'(ALU_SETC);
        OPCODE_W'(OP_CLRC): alu_op = ALU_OP_W'(ALU_CLRC);
        OPCODE_W'(OP_NOT):  begin alu_op = ALU_OP_W'(ALU_NOT); one_operand = 1'b1; end
        OPCODE_W'(OP_INC):  begin alu_op = ALU_OP_W'(ALU_INC); one_operand = 1'b1; end
        OPCODE_W'(OP_DEC):  begin alu_op = ALU_OP_W'(ALU_DEC); one_operand = 1'b1; end
        OPCODE_W'(OP_IN):   in_port   = 1'b1;
        OPCODE_W'(OP_OUT):  out_port  = 1'b1;
        OPCODE_W'(OP_PUSH): push      = 1'b1;
        OPCODE_W'(OP_POP):  pop       = 1'b1;
        OPCODE_W'(OP_LDD):  mem_read  = 1'b1;
        OPCODE_W'(OP_STD):  mem_write = 1'b1;
        OPCODE_W'(OP_LDM):  begin mem_read = 1'b1; imm = 1'b1; end
        OPCODE_W'(OP_MOV):  alu_op = ALU_OP_W'(ALU_MOV);
        OPCODE_W'(OP_ADD):  alu_op = ALU_OP_W'(ALU_ADD);
        OPCODE_W'(OP_SUB):  alu_op = ALU_OP_W'(ALU_SUB);
        OPCODE_W'(OP_AND):  alu_op = ALU_OP_W'(ALU_AND);
        OPCODE_W'(OP_OR):   alu_op = ALU_OP_W'(ALU_OR);
        OPCODE_W'(OP_SHL):  begin alu_op = ALU_OP_W'(ALU_SHL); imm = 1'b1; end
        OPCODE_W'(OP_SHR):  begin alu_op = ALU_OP_W'(ALU_SHR); imm = 1'b1; end
        OPCODE_W'(OP_JZ):   jump_type = JUMP_W'(J_JZ);
        OPCODE_W'(OP_JN):   jump_type = JUMP_W'(J_JN);
        OPCODE_W'(OP_JC):   jump_type = JUMP_W'(J_JC);
        OPCODE_W'(OP_JMP):  jump_type = JUMP_W'(J_JMP);
        OPCODE_W'(OP_CALL): seq_call  = 1'b1;
        OPCODE_W'(OP_RET):  seq_ret   = 1'b1;
        OPCODE_W'(OP_RETI): seq_reti  = 1'b1;
        default:            alu_op    = {ALU_OP_W{1'b0}};
      endcase
    end else begin
      alu_op = {ALU_OP_W{1'b0}};
    end
  end

  assign wb = calc_wb(alu_op != {ALU_OP_W{1'b0}}, mem_read, pop, in_port);

endmodule

// File: rtl/pipelined_control_unit.sv
// ID-stage control decode with EX/MEM/WB bundle pipeline, stall/flush handling
// and the CALL/RET/RETI micro-sequencer that drives push/pop word by word.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_D,
  parameter int ALU_OP_W = ALU_OP_W_D,
  parameter int JUMP_W   = JUMP_W_D,
  parameter int PC_WORDS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                valid_i,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic                id_mem_read,
  output logic                id_mem_write,
  output logic [ALU_OP_W-1:0] id_alu_op,
  output logic                id_wb,
  output logic                id_push,
  output logic                id_pop,
  output logic                id_in_port,
  output logic                id_out_port,
  output logic                id_imm,
  output logic [JUMP_W-1:0]   id_jump_type,
  output logic                id_one_operand,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_wb,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_dst_alu_sel,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic                mem_wb,
  output logic                wb_wb,
  output logic                wb_mem_read,
  output logic                seq_busy_o,
  output logic [1:0]          seq_word_o
);

  typedef struct packed {
    logic                mem_read;
    logic                mem_write;
    logic [ALU_OP_W-1:0] alu_op;
    logic                wb;
    logic                push;
    logic                pop;
    logic                in_port;
    logic                out_port;
    logic                imm;
    logic [JUMP_W-1:0]   jump_type;
    logic                one_operand;
  } id_bundle_t;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                wb;
    logic                mem_read;
    logic                mem_write;
    logic                dst_alu_sel;
  } ex_bundle_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic wb;
  } mem_bundle_t;

  typedef struct packed {
    logic wb;
    logic mem_read;
  } wb_bundle_t;

  localparam id_bundle_t ID_ZERO   = {$bits(id_bundle_t){1'b0}};
  localparam ex_bundle_t EX_ZERO   = {$bits(ex_bundle_t){1'b0}};
  localparam int         LAST_IDX  = PC_WORDS - 32'sd1;
  localparam logic [1:0] LAST_WORD = LAST_IDX[1:0];

  logic                dec_mem_read_s, dec_mem_write_s, dec_wb_s, dec_push_s, dec_pop_s;
  logic                dec_in_port_s, dec_out_port_s, dec_imm_s, dec_one_operand_s;
  logic                dec_call_s, dec_ret_s, dec_reti_s;
  logic [ALU_OP_W-1:0] dec_alu_op_s;
  logic [JUMP_W-1:0]   dec_jump_type_s;
  id_bundle_t          dec_bundle_s;

  seq_state_e  state_r, state_n_s, accept_state_s;
  logic [1:0]  word_r, word_n_s;
  id_bundle_t  id_r, id_n_s;
  logic        busy_r, busy_n_s;
  logic [1:0]  seq_word_r, seq_word_n_s;
  ex_bundle_t  ex_r, ex_n_s;
  mem_bundle_t mem_r;
  wb_bundle_t  wb_r;

  ctrl_decode #(
    .OPCODE_W (OPCODE_W),
    .ALU_OP_W (ALU_OP_W),
    .JUMP_W   (JUMP_W)
  ) u_decode (
    .opcode      (opcode_i),
    .valid       (valid_i),
    .mem_read    (dec_mem_read_s),
    .mem_write   (dec_mem_write_s),
    .alu_op      (dec_alu_op_s),
    .wb          (dec_wb_s),
    .push        (dec_push_s),
    .pop         (dec_pop_s),
    .in_port     (dec_in_port_s),
    .out_port    (dec_out_port_s),
    .imm         (dec_imm_s),
    .jump_type   (dec_jump_type_s),
    .one_operand (dec_one_operand_s),
    .seq_call    (dec_call_s),
    .seq_ret     (dec_ret_s),
    .seq_reti    (dec_reti_s)
  );

  assign dec_bundle_s = {dec_mem_read_s, dec_mem_write_s, dec_alu_op_s, dec_wb_s, dec_push_s,
                         dec_pop_s, dec_in_port_s, dec_out_port_s, dec_imm_s,
                         dec_jump_type_s, dec_one_operand_s};

  // sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      word_r  <= 2'd0;
    end else begin
      state_r <= state_n_s;
      word_r  <= word_n_s;
    end
  end

  // state a freshly accepted opcode starts in
  always_comb begin
    accept_state_s = ST_IDLE;
    if (dec_call_s) begin
      accept_state_s = ST_CALL_PUSH;
    end else if (dec_ret_s) begin
      accept_state_s = ST_RET_POP;
    end else if (dec_reti_s) begin
      accept_state_s = ST_RETI_FLAGS;
    end else begin
      accept_state_s = ST_IDLE;
    end
  end

  // sequencer next state; a new opcode is only taken in IDLE or on the last word
  always_comb begin
    state_n_s = state_r;
    word_n_s  = word_r;
    if (flush_i) begin
      state_n_s = ST_IDLE;
      word_n_s  = 2'd0;
    end else if (stall_i) begin
      state_n_s = state_r;
      word_n_s  = word_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_n_s = accept_state_s;
          word_n_s  = 2'd0;
        end
        ST_CALL_PUSH, ST_RET_POP, ST_RETI_POP: begin
          if (word_r == LAST_WORD) begin
            state_n_s = accept_state_s;
            word_n_s  = 2'd0;
          end else begin
            word_n_s = word_r + 2'd1;
          end
        end
        ST_RETI_FLAGS: begin
          state_n_s = ST_RETI_POP;
          word_n_s  = 2'd0;
        end
        default: begin
          state_n_s = ST_IDLE;
          word_n_s  = 2'd0;
        end
      endcase
    end
  end

  // next ID bundle and sequencer outputs, derived from the state entered at this edge
  always_comb begin
    id_n_s       = ID_ZERO;
    busy_n_s     = 1'b0;
    seq_word_n_s = 2'd0;
    if (flush_i) begin
      id_n_s = ID_ZERO;
    end else if (stall_i) begin
      id_n_s       = id_r;
      busy_n_s     = busy_r;
      seq_word_n_s = seq_word_r;
    end else begin
      case (state_n_s)
        ST_IDLE: id_n_s = dec_bundle_s;
        ST_CALL_PUSH: begin
          id_n_s.push      = 1'b1;
          id_n_s.jump_type = (word_n_s == LAST_WORD) ? JUMP_W'(J_CALL) : JUMP_W'(J_NONE);
          busy_n_s         = (word_n_s != LAST_WORD);
          seq_word_n_s     = word_n_s;
        end
        ST_RET_POP: begin
          id_n_s.pop       = 1'b1;
          id_n_s.jump_type = (word_n_s == LAST_WORD) ? JUMP_W'(J_RET) : JUMP_W'(J_NONE);
          busy_n_s         = (word_n_s != LAST_WORD);
          seq_word_n_s     = word_n_s;
        end
        ST_RETI_FLAGS: begin
          id_n_s.pop   = 1'b1;
          busy_n_s     = 1'b1;
          seq_word_n_s = 2'd0;
        end
        ST_RETI_POP: begin
          id_n_s.pop       = 1'b1;
          id_n_s.jump_type = (word_n_s == LAST_WORD) ? JUMP_W'(J_RETI) : JUMP_W'(J_NONE);
          busy_n_s         = (word_n_s != LAST_WORD);
          seq_word_n_s     = word_n_s;
        end
        default: id_n_s = ID_ZERO;
      endcase
    end
  end

  // EX input: stall and flush both inject a bubble
  always_comb begin
    ex_n_s = EX_ZERO;
    if (flush_i || stall_i) begin
      ex_n_s = EX_ZERO;
    end else begin
      ex_n_s.alu_op      = id_r.alu_op;
      ex_n_s.wb          = id_r.wb;
      ex_n_s.mem_read    = id_r.mem_read;
      ex_n_s.mem_write   = id_r.mem_write;
      ex_n_s.dst_alu_sel = (id_r.alu_op != {ALU_OP_W{1'b0}});
    end
  end

  // ID/EX/MEM/WB stage registers; MEM and WB always advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_r       <= ID_ZERO;
      busy_r     <= 1'b0;
      seq_word_r <= 2'd0;
      ex_r       <= EX_ZERO;
      mem_r      <= 3'b000;
      wb_r       <= 2'b00;
    end else begin
      id_r       <= id_n_s;
      busy_r     <= busy_n_s;
      seq_word_r <= seq_word_n_s;
      ex_r       <= ex_n_s;
      mem_r      <= {ex_r.mem_read, ex_r.mem_write, ex_r.wb};
      wb_r       <= {mem_r.wb, mem_r.mem_read};
    end
  end

  assign id_mem_read    = id_r.mem_read;
  assign id_mem_write   = id_r.mem_write;
  assign id_alu_op      = id_r.alu_op;
  assign id_wb          = id_r.wb;
  assign id_push        = id_r.push;
  assign id_pop         = id_r.pop;
  assign id_in_port     = id_r.in_port;
  assign id_out_port    = id_r.out_port;
  assign id_imm         = id_r.imm;
  assign id_jump_type   = id_r.jump_type;
  assign id_one_operand = id_r.one_operand;
  assign ex_alu_op      = ex_r.alu_op;
  assign ex_wb          = ex_r.wb;
  assign ex_mem_read    = ex_r.mem_read;
  assign ex_mem_write   = ex_r.mem_write;
  assign ex_dst_alu_sel = ex_r.dst_alu_sel;
  assign mem_mem_read   = mem_r.mem_read;
  assign mem_mem_write  = mem_r.mem_write;
  assign mem_wb         = mem_r.wb;
  assign wb_wb          = wb_r.wb;
  assign wb_mem_read    = wb_r.mem_read;
  assign seq_busy_o     = busy_r;
  assign seq_word_o     = seq_word_r;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: decode, pipeline timing, stall/flush,
// CALL/RETI sequencing and asynchronous reset, with hand-computed expectations.
module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] opcode_i;
  logic       valid_i, stall_i, flush_i;
  logic       id_mem_read, id_mem_write, id_wb, id_push, id_pop, id_in_port, id_out_port;
  logic       id_imm, id_one_operand;
  logic [3:0] id_alu_op, ex_alu_op;
  logic [2:0] id_jump_type;
  logic       ex_wb, ex_mem_read, ex_mem_write, ex_dst_alu_sel;
  logic       mem_mem_read, mem_mem_write, mem_wb, wb_wb, wb_mem_read, seq_busy_o;
  logic [1:0] seq_word_o;
  logic [31:0] all_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode_i), .valid_i(valid_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
    .id_wb(id_wb), .id_push(id_push), .id_pop(id_pop), .id_in_port(id_in_port),
    .id_out_port(id_out_port), .id_imm(id_imm), .id_jump_type(id_jump_type),
    .id_one_operand(id_one_operand),
    .ex_alu_op(ex_alu_op), .ex_wb(ex_wb), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_dst_alu_sel(ex_dst_alu_sel),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_wb(mem_wb),
    .wb_wb(wb_wb), .wb_mem_read(wb_mem_read),
    .seq_busy_o(seq_busy_o), .seq_word_o(seq_word_o)
  );

  assign all_out = {id_mem_read, id_mem_write, id_alu_op, id_wb, id_push, id_pop, id_in_port,
                    id_out_port, id_imm, id_jump_type, id_one_operand,
                    ex_alu_op, ex_wb, ex_mem_read, ex_mem_write, ex_dst_alu_sel,
                    mem_mem_read, mem_mem_write, mem_wb, wb_wb, wb_mem_read,
                    seq_busy_o, seq_word_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic v, input logic st, input logic fl);
    opcode_i = op;
    valid_i  = v;
    stall_i  = st;
    flush_i  = fl;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("reset_all", all_out, 32'd0);
    rst_n = 1'b1;

    // ADD through all four stages
    drive(5'd25, 1'b1, 1'b0, 1'b0); cyc();
    chk("add_id_alu", {28'd0, id_alu_op}, 32'd5);
    chk("add_id_wb", {31'd0, id_wb}, 32'd1);
    chk("add_id_oneop", {31'd0, id_one_operand}, 32'd0);
    drive(5'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("add_ex_alu", {28'd0, ex_alu_op}, 32'd5);
    chk("add_ex_dst", {31'd0, ex_dst_alu_sel}, 32'd1);
    chk("bubble_id_alu", {28'd0, id_alu_op}, 32'd0);
    cyc();
    chk("add_mem_wb", {31'd0, mem_wb}, 32'd1);
    chk("add_ex_wb_gone", {31'd0, ex_wb}, 32'd0);
    cyc();
    chk("add_wb_wb", {31'd0, wb_wb}, 32'd1);
    chk("add_wb_memrd", {31'd0, wb_mem_read}, 32'd0);

    // INC is single-operand
    drive(5'd4, 1'b1, 1'b0, 1'b0); cyc();
    chk("inc_alu", {28'd0, id_alu_op}, 32'd2);
    chk("inc_oneop", {31'd0, id_one_operand}, 32'd1);

    // LDM then one stall cycle
    drive(5'd13, 1'b1, 1'b0, 1'b0); cyc();
    chk("ldm_id", {30'd0, id_mem_read, id_imm}, 32'd3);
    chk("ldm_id_wb", {31'd0, id_wb}, 32'd1);
    drive(5'd25, 1'b1, 1'b1, 1'b0); cyc();
    chk("stall_id_hold", {30'd0, id_mem_read, id_imm}, 32'd3);
    chk("stall_id_alu", {28'd0, id_alu_op}, 32'd0);
    chk("stall_ex_bubble", {30'd0, ex_mem_read, ex_wb}, 32'd0);
    drive(5'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("ldm_ex", {30'd0, ex_mem_read, ex_wb}, 32'd3);
    chk("ldm_id_cleared", {31'd0, id_mem_read}, 32'd0);
    cyc();
    chk("ldm_mem", {31'd0, mem_mem_read}, 32'd1);
    chk("ldm_ex_after", {31'd0, ex_mem_read}, 32'd0);

    // flush wins over stall
    drive(5'd25, 1'b1, 1'b0, 1'b0); cyc();
    chk("pre_flush_id", {28'd0, id_alu_op}, 32'd5);
    drive(5'd25, 1'b1, 1'b1, 1'b1); cyc();
    chk("flush_stall_id", {28'd0, id_alu_op}, 32'd0);
    chk("flush_stall_ex", {28'd0, ex_alu_op}, 32'd0);

    // CALL, two PC words; ADD waits until the last word
    drive(5'd20, 1'b1, 1'b0, 1'b0); cyc();
    chk("call_w0", {24'd0, id_push, id_jump_type, seq_busy_o, seq_word_o, id_wb}, 32'h80 | 32'h08);
    drive(5'd25, 1'b1, 1'b0, 1'b0); cyc();
    chk("call_w1", {24'd0, id_push, id_jump_type, seq_busy_o, seq_word_o, id_wb}, 32'hD2);
    chk("call_w1_alu", {28'd0, id_alu_op}, 32'd0);
    cyc();
    chk("after_call_add", {28'd0, id_alu_op}, 32'd5);
    chk("after_call_push", {28'd0, id_push, id_jump_type}, 32'd0);

    // RETI: flags word then two PC words
    drive(5'd22, 1'b1, 1'b0, 1'b0); cyc();
    chk("reti_flags", {24'd0, id_pop, id_jump_type, seq_busy_o, seq_word_o, id_wb}, 32'h88);
    drive(5'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("reti_w0", {24'd0, id_pop, id_jump_type, seq_busy_o, seq_word_o, id_wb}, 32'h88);
    cyc();
    chk("reti_w1", {24'd0, id_pop, id_jump_type, seq_busy_o, seq_word_o, id_wb}, 32'hF2);
    cyc();
    chk("reti_done", {24'd0, id_pop, id_jump_type, seq_busy_o, seq_word_o, id_wb}, 32'd0);

    // RETI flushed on its 2nd cycle
    drive(5'd22, 1'b1, 1'b0, 1'b0); cyc();
    chk("retif_flags", {30'd0, id_pop, seq_busy_o}, 32'd3);
    drive(5'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("retif_w0", {30'd0, id_pop, seq_busy_o}, 32'd3);
    drive(5'd0, 1'b0, 1'b0, 1'b1); cyc();
    chk("retif_flushed", {24'd0, id_pop, id_jump_type, seq_busy_o, seq_word_o, id_wb}, 32'd0);
    drive(5'd25, 1'b1, 1'b0, 1'b0); cyc();
    chk("retif_idle_add", {27'd0, id_alu_op, id_pop}, 32'h0A);

    // drain, then unused opcodes and bubbles must stay zero everywhere
    drive(5'd0, 1'b0, 1'b0, 1'b0); cyc(); cyc(); cyc(); cyc();
    chk("drained", all_out, 32'd0);
    drive(5'd11, 1'b1, 1'b0, 1'b0); cyc();
    chk("op11_zero", all_out, 32'd0);
    drive(5'd27, 1'b1, 1'b0, 1'b0); cyc();
    chk("op27_zero", all_out, 32'd0);
    drive(5'd25, 1'b0, 1'b0, 1'b0); cyc();
    chk("invalid_add_zero", all_out, 32'd0);
    drive(5'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("unused_drain1", all_out, 32'd0);
    cyc();
    chk("unused_drain2", all_out, 32'd0);

    // asynchronous reset during the 2nd word of RET
    drive(5'd21, 1'b1, 1'b0, 1'b0); cyc();
    chk("ret_w0", {27'd0, id_pop, seq_busy_o, seq_word_o, id_wb}, 32'h18);
    drive(5'd0, 1'b0, 1'b0, 1'b0); cyc();
    chk("ret_w1", {24'd0, id_pop, id_jump_type, seq_busy_o, seq_word_o, id_wb}, 32'hE2);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", all_out, 32'd0);
    cyc();
    chk("reset_held", all_out, 32'd0);
    rst_n = 1'b1;
    drive(5'd25, 1'b1, 1'b0, 1'b0); cyc();
    chk("post_reset_add", {24'd0, id_alu_op, id_pop, seq_busy_o, seq_word_o}, 32'h50);
    chk("post_reset_jump", {29'd0, id_jump_type}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
